// File: rtl/qs_pkg.sv
// qs_pkg: shared Q16.16 types and order-generator state encoding
package qs_pkg;
    typedef logic signed [31:0] q16_t;
    localparam q16_t Q16_ONE = 32'sd65536;
    typedef enum logic [2:0] {IDLE, EVAL, SEND, COOL, HALT} qs_ord_state_e;
endpackage

// File: rtl/qs_pos_clip.sv
// qs_pos_clip: order quantity clipped to the remaining position headroom
module qs_pos_clip #(
    parameter int DATA_W    = 32,
    parameter int ORDER_QTY = 65536,
    parameter int POS_LIMIT = 196608
) (
    input  logic signed [DATA_W-1:0] pos,
    input  logic                     side,
    output logic        [DATA_W-1:0] qty,
    output logic                     zero
);
    localparam logic signed [DATA_W:0] LIM = (DATA_W+1)'(POS_LIMIT);
    localparam logic signed [DATA_W:0] OQ  = (DATA_W+1)'(ORDER_QTY);
    logic signed [DATA_W:0] head, wide;
    assign head = side ? LIM - {pos[DATA_W-1], pos} : LIM + {pos[DATA_W-1], pos};
    assign wide = head < OQ ? head : OQ;
    assign zero = wide[DATA_W] || wide == '0;
    assign qty  = wide[DATA_W-1:0];
endmodule

// File: rtl/qs_order_gen.sv
// qs_order_gen: turns accepted strategy samples into position-limited orders
module qs_order_gen
    import qs_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int THRESH    = 16384,
    parameter int ORDER_QTY = 65536,
    parameter int POS_LIMIT = 196608,
    parameter int COOLDOWN  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sig_valid,
    output logic                     sig_ready,
    input  logic signed [DATA_W-1:0] signal_in,
    input  logic                     allow_in,
    input  logic                     kill_in,
    output logic                     ord_valid,
    input  logic                     ord_ready,
    output logic                     ord_side,
    output logic        [DATA_W-1:0] ord_qty,
    output logic signed [DATA_W-1:0] position_out,
    output logic                     halted,
    input  logic                     clear_halt,
    output logic [15:0]              drop_cnt
);
    localparam int CW = $clog2(COOLDOWN + 2);
    localparam logic signed [DATA_W-1:0] TH = DATA_W'(THRESH);
    qs_ord_state_e state, state_n;
    logic signed [DATA_W-1:0] sig_r, sig_n, pos_n;
    logic allow_r, allow_n, kill_r, kill_n, valid_n, side_n, buy, trig, zero;
    logic [DATA_W-1:0] qty_n, clip_qty;
    logic [15:0] drop_n;
    logic [CW-1:0] cnt, cnt_n;
    assign buy  = !sig_r[DATA_W-1] && |sig_r;
    assign trig = sig_r > TH || sig_r < -TH;
    qs_pos_clip #(.DATA_W(DATA_W), .ORDER_QTY(ORDER_QTY), .POS_LIMIT(POS_LIMIT)) u_clip (
        .pos(position_out), .side(buy), .qty(clip_qty), .zero(zero)
    );
    // next-state and next-output decode; every register reloads itself by default
    always_comb begin
        state_n = state;
        sig_n   = sig_r;
        allow_n = allow_r;
        kill_n  = kill_r;
        valid_n = ord_valid;
        side_n  = ord_side;
        qty_n   = ord_qty;
        pos_n   = position_out;
        drop_n  = drop_cnt;
        cnt_n   = cnt;
        case (state)
            IDLE: if (sig_valid && sig_ready) begin
                sig_n   = signal_in;
                allow_n = allow_in;
                kill_n  = kill_in;
                state_n = EVAL;
            end
            EVAL: if (kill_r) state_n = HALT;
                else if (!allow_r || !trig || zero) begin
                    drop_n  = drop_cnt + 16'(drop_cnt != 16'hFFFF);
                    state_n = IDLE;
                end else begin
                    valid_n = 1'b1;
                    side_n  = buy;
                    qty_n   = clip_qty;
                    state_n = SEND;
                end
            SEND: if (ord_ready) begin
                pos_n   = ord_side ? position_out + $signed(ord_qty) : position_out - $signed(ord_qty);
                valid_n = 1'b0;
                cnt_n   = CW'(COOLDOWN);
                state_n = COOLDOWN > 0 ? COOL : IDLE;
            end
            COOL: begin
                cnt_n   = cnt - 1'b1;
                state_n = cnt <= 1 ? IDLE : COOL;
            end
            HALT: state_n = clear_halt ? IDLE : HALT;
            default: state_n = IDLE;
        endcase
    end
    // state and output registers; ready/halted decode the upcoming state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            sig_ready    <= 1'b0;
            halted       <= 1'b0;
            sig_r        <= '0;
            allow_r      <= 1'b0;
            kill_r       <= 1'b0;
            ord_valid    <= 1'b0;
            ord_side     <= 1'b0;
            ord_qty      <= '0;
            position_out <= '0;
            drop_cnt     <= '0;
            cnt          <= '0;
        end else begin
            state        <= state_n;
            sig_ready    <= state_n == IDLE || state_n == HALT;
            halted       <= state_n == HALT;
            sig_r        <= sig_n;
            allow_r      <= allow_n;
            kill_r       <= kill_n;
            ord_valid    <= valid_n;
            ord_side     <= side_n;
            ord_qty      <= qty_n;
            position_out <= pos_n;
            drop_cnt     <= drop_n;
            cnt          <= cnt_n;
        end
    end
endmodule

// File: tb/tb_qs_order_gen.sv
// tb_qs_order_gen: table-driven and sequence checks with an order scoreboard
module tb_qs_order_gen;
    typedef struct {
        logic signed [31:0] sig;
        logic allow, kill, ord, side;
        logic [31:0] qty;
        logic signed [31:0] pos;
        logic [15:0] drop;
    } vec_t;
    typedef struct { logic side; logic [31:0] qty; } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, sig_valid = 1'b0, allow_in = 1'b0, kill_in = 1'b0;
    logic ord_ready = 1'b1, clear_halt = 1'b0, sel = 1'b0;
    logic signed [31:0] signal_in = '0;
    logic r0_ready, r1_ready, r0_valid, r1_valid, r0_side, r1_side, r0_halt, r1_halt;
    logic [31:0] r0_qty, r1_qty;
    logic signed [31:0] r0_pos, r1_pos;
    logic [15:0] r0_drop, r1_drop;
    logic o_ready, o_valid, o_side, o_halt;
    logic [31:0] o_qty;
    logic signed [31:0] o_pos;
    logic [15:0] o_drop;
    int checks = 0, errors = 0;
    exp_t q[$];
    exp_t e;
    vec_t tab0[12];
    vec_t tab1[4];

    always #5 clk = ~clk;

    qs_order_gen dut (
        .clk(clk), .rst_n(rst_n), .sig_valid(sig_valid & ~sel), .sig_ready(r0_ready),
        .signal_in(signal_in), .allow_in(allow_in), .kill_in(kill_in),
        .ord_valid(r0_valid), .ord_ready(ord_ready), .ord_side(r0_side), .ord_qty(r0_qty),
        .position_out(r0_pos), .halted(r0_halt), .clear_halt(clear_halt & ~sel), .drop_cnt(r0_drop)
    );
    qs_order_gen #(.ORDER_QTY(131072)) dut2 (
        .clk(clk), .rst_n(rst_n), .sig_valid(sig_valid & sel), .sig_ready(r1_ready),
        .signal_in(signal_in), .allow_in(allow_in), .kill_in(kill_in),
        .ord_valid(r1_valid), .ord_ready(ord_ready), .ord_side(r1_side), .ord_qty(r1_qty),
        .position_out(r1_pos), .halted(r1_halt), .clear_halt(clear_halt & sel), .drop_cnt(r1_drop)
    );

    assign o_ready = sel ? r1_ready : r0_ready;
    assign o_valid = sel ? r1_valid : r0_valid;
    assign o_side  = sel ? r1_side  : r0_side;
    assign o_qty   = sel ? r1_qty   : r0_qty;
    assign o_pos   = sel ? r1_pos   : r0_pos;
    assign o_halt  = sel ? r1_halt  : r0_halt;
    assign o_drop  = sel ? r1_drop  : r0_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!o_ready && n < 64) begin
            n++;
            step();
        end
        if (!o_ready) chk("ready_timeout", o_ready, 1);
    endtask

    task automatic accept(input logic signed [31:0] s, input logic a, input logic k);
        int n;
        wait_ready(n);
        sig_valid = 1'b1;
        signal_in = s;
        allow_in  = a;
        kill_in   = k;
        step();
        sig_valid = 1'b0;
    endtask

    task automatic run_row(input vec_t v);
        int n;
        accept(v.sig, v.allow, v.kill);
        if (v.ord) q.push_back('{v.side, v.qty});
        wait_ready(n);
        if (!v.ord) chk("drop_latency", n, 1);
        chk("row_sb_empty", q.size(), 0);
        chk("row_position", o_pos, v.pos);
        chk("row_drop_cnt", o_drop, v.drop);
        chk("row_ord_valid", o_valid, 0);
    endtask

    // scoreboard: each handshake about to happen pops one expected order
    always @(negedge clk) begin
        if (rst_n && o_valid && ord_ready) begin
            chk("order_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ord_side", o_side, e.side);
                chk("ord_qty", o_qty, e.qty);
            end
        end
    end

    initial begin
        int n;
        tab0[0]  = '{32'sd6554,     1, 0, 0, 0, 32'd0,     32'sd65536,  16'd1};
        tab0[1]  = '{-32'sd32768,   0, 0, 0, 0, 32'd0,     32'sd65536,  16'd2};
        tab0[2]  = '{32'sd16384,    1, 0, 0, 0, 32'd0,     32'sd65536,  16'd3};
        tab0[3]  = '{-32'sd16384,   1, 0, 0, 0, 32'd0,     32'sd65536,  16'd4};
        tab0[4]  = '{32'sd16385,    1, 0, 1, 1, 32'd65536, 32'sd131072, 16'd4};
        tab0[5]  = '{32'sd32768,    1, 0, 1, 1, 32'd65536, 32'sd196608, 16'd4};
        tab0[6]  = '{32'sd32768,    1, 0, 0, 0, 32'd0,     32'sd196608, 16'd5};
        tab0[7]  = '{32'sh80000000, 1, 0, 1, 0, 32'd65536, 32'sd131072, 16'd5};
        tab0[8]  = '{-32'sd65536,   1, 0, 1, 0, 32'd65536, 32'sd65536,  16'd5};
        tab0[9]  = '{32'sh7fffffff, 1, 0, 1, 1, 32'd65536, 32'sd131072, 16'd5};
        tab0[10] = '{-32'sd32768,   1, 0, 1, 0, 32'd65536, 32'sd65536,  16'd5};
        tab0[11] = '{32'sd0,        1, 0, 0, 0, 32'd0,     32'sd65536,  16'd6};
        tab1[0]  = '{32'sd32768,    1, 0, 1, 1, 32'd131072, 32'sd131072, 16'd0};
        tab1[1]  = '{32'sd32768,    1, 0, 1, 1, 32'd65536,  32'sd196608, 16'd0};
        tab1[2]  = '{32'sd32768,    1, 0, 0, 0, 32'd0,      32'sd196608, 16'd1};
        tab1[3]  = '{-32'sd32768,   1, 0, 1, 0, 32'd131072, 32'sd65536,  16'd1};
        step();
        chk("rst_sig_ready", o_ready, 0);
        chk("rst_ord_valid", o_valid, 0);
        chk("rst_ord_side", o_side, 0);
        chk("rst_ord_qty", o_qty, 0);
        chk("rst_position", o_pos, 0);
        chk("rst_halted", o_halt, 0);
        chk("rst_drop_cnt", o_drop, 0);
        rst_n = 1'b1;
        step();
        chk("rel_sig_ready", o_ready, 1);
        accept(32'sd32768, 1, 0);
        q.push_back('{1'b1, 32'd65536});
        chk("lat_valid_eval", o_valid, 0);
        chk("lat_ready_eval", o_ready, 0);
        step();
        chk("lat_valid_send", o_valid, 1);
        chk("lat_ready_send", o_ready, 0);
        step();
        chk("first_valid_done", o_valid, 0);
        chk("first_position", o_pos, 65536);
        wait_ready(n);
        chk("cool_low_cycles", n, 4);
        foreach (tab0[i]) run_row(tab0[i]);
        ord_ready = 1'b0;
        accept(32'sd32768, 1, 0);
        q.push_back('{1'b1, 32'd65536});
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", o_valid, 1);
            chk("stall_side", o_side, 1);
            chk("stall_qty", o_qty, 65536);
            chk("stall_position", o_pos, 65536);
            step();
        end
        ord_ready = 1'b1;
        step();
        chk("stall_valid_done", o_valid, 0);
        chk("stall_position_done", o_pos, 131072);
        wait_ready(n);
        accept(32'sd58982, 1, 1);
        step();
        chk("kill_halted", o_halt, 1);
        chk("kill_ready", o_ready, 1);
        chk("kill_no_order", o_valid, 0);
        for (int i = 0; i < 3; i++) begin
            sig_valid = 1'b1;
            signal_in = 32'sd32768;
            kill_in   = 1'b0;
            step();
            sig_valid = 1'b0;
            chk("halt_ready", o_ready, 1);
            chk("halt_halted", o_halt, 1);
            chk("halt_drop_cnt", o_drop, 6);
            chk("halt_valid", o_valid, 0);
        end
        sig_valid  = 1'b1;
        clear_halt = 1'b1;
        step();
        sig_valid  = 1'b0;
        clear_halt = 1'b0;
        chk("clear_halted", o_halt, 0);
        chk("clear_position", o_pos, 131072);
        chk("clear_drop_cnt", o_drop, 6);
        step();
        chk("clear_sample_discarded", o_ready, 1);
        chk("clear_no_order", o_valid, 0);
        ord_ready = 1'b0;
        accept(32'sd32768, 1, 0);
        step();
        chk("rsend_valid", o_valid, 1);
        rst_n = 1'b0;
        step();
        chk("rsend_valid_cleared", o_valid, 0);
        chk("rsend_position", o_pos, 0);
        chk("rsend_drop_cnt", o_drop, 0);
        chk("rsend_ready_low", o_ready, 0);
        rst_n = 1'b1;
        step();
        chk("rsend_ready_after", o_ready, 1);
        q.delete();
        ord_ready = 1'b1;
        sel = 1'b1;
        foreach (tab1[i]) run_row(tab1[i]);
        chk("final_sb_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
